// File: rtl/lcd_rx_capture_pkg.sv
// Shared constants for the LCD receive path: coordinate width, FIFO entry
// layout and a saturating counter helper.
package lcd_rx_capture_pkg;

  localparam int CW    = 11;
  localparam int RGB_W = 24;
  localparam int ENT_W = 48;

  // Entry field offsets (LSB first): data, x, y, sof, eol
  localparam int OFS_DATA = 0;
  localparam int OFS_X    = 24;
  localparam int OFS_Y    = 35;
  localparam int OFS_SOF  = 46;
  localparam int OFS_EOL  = 47;

  localparam logic [CW-1:0] CMAX = '1;

  typedef struct packed {
    logic             eol;
    logic             sof;
    logic [CW-1:0]    y;
    logic [CW-1:0]    x;
    logic [RGB_W-1:0] data;
  } pix_ent_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

endpackage

// File: rtl/lcd_rx_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on rdata whenever not
// empty. A push while full is accepted only if a pop happens in the same cycle.
module lcd_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcd_rx_capture.sv
// Parallel RGB LCD receiver: recovers frame/line structure, measures active
// size and line period, declares lock after two matching frames, and
// forwards active pixels with coordinates through a show-ahead FIFO.
// Optional: LCD_RX_FRAME_GATE_EN forwards only frames that start locked.
module lcd_rx_capture
  import lcd_rx_capture_pkg::*;
#(
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_hs,
  input  logic              vid_vs,
  input  logic              vid_de,
  input  logic [RGB_W-1:0]  vid_rgb,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [RGB_W-1:0]  pix_data,
  output logic [CW-1:0]     pix_x,
  output logic [CW-1:0]     pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [CW-1:0]     meas_width,
  output logic [CW-1:0]     meas_height,
  output logic [CW-1:0]     meas_htotal,
  output logic              locked,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam logic [0:0] SEEK  = 1'b0;
  localparam logic [0:0] FRAME = 1'b1;

  logic             hs_a, vs_a, de1, hs_a_d, vs_a_d, de1_d;
  logic [RGB_W-1:0] rgb1;
  logic             hs_edge, vs_edge, de_fall;

  // S1 input stage plus one-cycle history; syncs kept as "active" flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_a <= 1'b0; vs_a <= 1'b0; de1 <= 1'b0; rgb1 <= '0;
      hs_a_d <= 1'b0; vs_a_d <= 1'b0; de1_d <= 1'b0;
    end else begin
      hs_a   <= (vid_hs == HS_POL);
      vs_a   <= (vid_vs == VS_POL);
      de1    <= vid_de;
      rgb1   <= vid_rgb;
      hs_a_d <= hs_a;
      vs_a_d <= vs_a;
      de1_d  <= de1;
    end
  end

  assign hs_edge = hs_a && !hs_a_d;
  assign vs_edge = vs_a && !vs_a_d;
  assign de_fall = de1_d && !de1;

  logic [0:0]    state;
  logic [CW-1:0] x_cnt, y_cnt, first_w, prev_w, prev_h;
  logic          incons, prev_ok, frame_ok, lock_nxt;

  // Verdict for the frame that ends at this VS assertion
  always_comb begin
    frame_ok = (y_cnt != '0) && !incons;
    lock_nxt = frame_ok && prev_ok && (first_w == prev_w) && (y_cnt == prev_h);
  end

  // Capture FSM, coordinate counters and per-frame measurement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEEK; x_cnt <= '0; y_cnt <= '0; first_w <= '0;
      prev_w <= '0; prev_h <= '0; incons <= 1'b0; prev_ok <= 1'b0;
      meas_width <= '0; meas_height <= '0; locked <= 1'b0;
    end else if (vs_edge) begin
      state  <= FRAME;
      x_cnt  <= '0;
      y_cnt  <= '0;
      incons <= 1'b0;
      if (state == FRAME) begin
        if (y_cnt != '0) begin
          meas_width  <= first_w;
          meas_height <= y_cnt;
        end
        locked  <= lock_nxt;
        prev_ok <= frame_ok;
        prev_w  <= first_w;
        prev_h  <= y_cnt;
      end
    end else if (state == FRAME) begin
      if (de1) begin
        x_cnt <= sat_inc(x_cnt);
      end else if (de_fall && (x_cnt != '0)) begin
        x_cnt <= '0;
        y_cnt <= sat_inc(y_cnt);
        if (y_cnt == '0)          first_w <= x_cnt;
        else if (x_cnt != first_w) incons  <= 1'b1;
      end
    end
  end

  logic [CW-1:0] h_cnt;
  logic          h_primed;

  // Line period: clocks between successive HS assertion edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0; h_primed <= 1'b0; meas_htotal <= '0;
    end else if (hs_edge) begin
      h_cnt    <= CW'(1);
      h_primed <= 1'b1;
      if (h_primed) meas_htotal <= h_cnt;
    end else begin
      h_cnt <= sat_inc(h_cnt);
    end
  end

  logic pix_in;

`ifdef LCD_RX_FRAME_GATE_EN
  logic fwd;

  // Forward permission for a whole frame, taken from the lock decision at its start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fwd <= 1'b0;
    else if (vs_edge) fwd <= (state == FRAME) && lock_nxt;
  end

  assign pix_in = (state == FRAME) && de1 && !vs_edge && fwd;
`else
  assign pix_in = (state == FRAME) && de1 && !vs_edge;
`endif

  logic     wr_vld;
  pix_ent_t wr_ent;

  // Write stage: eol comes from the raw DE seen alongside, i.e. the next pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld <= 1'b0;
      wr_ent <= '0;
    end else begin
      wr_vld <= pix_in;
      if (pix_in)
        wr_ent <= '{eol: !vid_de, sof: (x_cnt == '0) && (y_cnt == '0),
                    y: y_cnt, x: x_cnt, data: rgb1};
    end
  end

  pix_ent_t fifo_rdata, head;
  logic     fifo_full, fifo_empty, pop;

  assign pop = pix_valid && pix_ready;

  lcd_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(ENT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_vld),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pix_valid = !fifo_empty;
  assign head      = pix_valid ? fifo_rdata : '0;
  assign pix_data  = head.data;
  assign pix_x     = head.x;
  assign pix_y     = head.y;
  assign pix_sof   = head.sof;
  assign pix_eol   = head.eol;

  // Sticky overflow; a drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           ovf <= 1'b0;
    else if (wr_vld && fifo_full && !pop) ovf <= 1'b1;
    else if (ovf_clr)                     ovf <= 1'b0;
  end

endmodule
